// File: rtl/spi_regs_pkg.sv
// Shared constants for the SPI register target: frame size, register map and FSM states.
package spi_regs_pkg;

    localparam int FRAME_BITS = 16;

    localparam logic [6:0] ADDR_EN_OUT    = 7'h00;
    localparam logic [6:0] ADDR_EN_PWM    = 7'h01;
    localparam logic [6:0] ADDR_CH_3_0    = 7'h02;
    localparam logic [6:0] ADDR_CH_7_4    = 7'h03;
    localparam logic [6:0] ADDR_DUTY_1    = 7'h04;
    localparam logic [6:0] ADDR_DUTY_2    = 7'h05;
    localparam logic [6:0] ADDR_DUTY_3    = 7'h06;
    localparam logic [6:0] ADDR_DUTY_4    = 7'h07;
    localparam logic [6:0] ADDR_FREQ_DIV  = 7'h08;

    // One past a full frame: any further sclk edges leave the counter parked here.
    localparam logic [4:0] CNT_OVERRUN    = 5'd17;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_e;

endpackage

// File: rtl/spi_peripheral_sync_edge.sv
// Multi-flop synchroniser for one asynchronous line, with registered-history edge detection.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Resetting to 0 means a line already low at reset release never reports a falling edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI target: validates 16-bit frames and drives the PWM configuration registers.
module spi_peripheral
    import spi_regs_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h08
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] reg_en_out,
    output logic [7:0] reg_en_pwm_out,
    output logic [7:0] reg_out_3_0_pwm_chanel,
    output logic [7:0] reg_out_7_4_pwm_chanel,
    output logic [7:0] reg_pwm_gen_1_duty_cycle,
    output logic [7:0] reg_pwm_gen_2_duty_cycle,
    output logic [7:0] reg_pwm_gen_3_duty_cycle,
    output logic [7:0] reg_pwm_gen_4_duty_cycle,
    output logic [3:0] reg_pwm_frequency_divider,
    output logic       txn_done,
    output logic       txn_err
);

    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_s, ncs_rise, ncs_fall;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i(clk), .rst_ni(rst_n), .d_i(sclk), .q_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk_i(clk), .rst_ni(rst_n), .d_i(copi), .q_o(copi_s), .rise_o(copi_rise), .fall_o(copi_fall));
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk_i(clk), .rst_ni(rst_n), .d_i(ncs), .q_o(ncs_s), .rise_o(ncs_rise), .fall_o(ncs_fall));

    state_e      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;

    logic [7:0]  en_out_q, en_pwm_q, ch_3_0_q, ch_7_4_q;
    logic [7:0]  duty1_q, duty2_q, duty3_q, duty4_q;
    logic [3:0]  fdiv_q;
    logic        done_q, err_q;

    logic [6:0]  addr;
    logic [7:0]  data;
    logic        commit, valid;

    assign addr   = shift_q[14:8];
    assign data   = shift_q[7:0];
    assign commit = (state_q == COMMIT);
    assign valid  = (cnt_q == 5'(FRAME_BITS)) && shift_q[15] && (addr <= MAX_ADDR);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else if (sclk_rise) begin
                    shift_d = {shift_q[14:0], copi_s};
                    cnt_d   = (cnt_q == CNT_OVERRUN) ? CNT_OVERRUN : cnt_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Register file: exactly one register may change, only in the single COMMIT cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_out_q <= '0;
            en_pwm_q <= '0;
            ch_3_0_q <= '0;
            ch_7_4_q <= '0;
            duty1_q  <= '0;
            duty2_q  <= '0;
            duty3_q  <= '0;
            duty4_q  <= '0;
            fdiv_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= commit && valid;
            err_q  <= commit && !valid;
            if (commit && valid) begin
                case (addr)
                    ADDR_EN_OUT:   en_out_q <= data;
                    ADDR_EN_PWM:   en_pwm_q <= data;
                    ADDR_CH_3_0:   ch_3_0_q <= data;
                    ADDR_CH_7_4:   ch_7_4_q <= data;
                    ADDR_DUTY_1:   duty1_q  <= data;
                    ADDR_DUTY_2:   duty2_q  <= data;
                    ADDR_DUTY_3:   duty3_q  <= data;
                    ADDR_DUTY_4:   duty4_q  <= data;
                    ADDR_FREQ_DIV: fdiv_q   <= data[3:0];
                    default: ;
                endcase
            end
        end
    end

    assign reg_en_out                = en_out_q;
    assign reg_en_pwm_out            = en_pwm_q;
    assign reg_out_3_0_pwm_chanel    = ch_3_0_q;
    assign reg_out_7_4_pwm_chanel    = ch_7_4_q;
    assign reg_pwm_gen_1_duty_cycle  = duty1_q;
    assign reg_pwm_gen_2_duty_cycle  = duty2_q;
    assign reg_pwm_gen_3_duty_cycle  = duty3_q;
    assign reg_pwm_gen_4_duty_cycle  = duty4_q;
    assign reg_pwm_frequency_divider = fdiv_q;
    assign txn_done                  = done_q;
    assign txn_err                   = err_q;

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: table of SPI frames plus hand sequences, scoreboard checks each pulse.
module tb_spi_peripheral;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n, sclk, copi, ncs;
    logic [7:0] reg_en_out, reg_en_pwm_out, reg_out_3_0_pwm_chanel, reg_out_7_4_pwm_chanel;
    logic [7:0] d1, d2, d3, d4;
    logic [3:0] fdiv;
    logic txn_done, txn_err;

    spi_peripheral #(.SYNC_STAGES(S), .MAX_ADDR(7'h08)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .reg_en_out(reg_en_out), .reg_en_pwm_out(reg_en_pwm_out),
        .reg_out_3_0_pwm_chanel(reg_out_3_0_pwm_chanel),
        .reg_out_7_4_pwm_chanel(reg_out_7_4_pwm_chanel),
        .reg_pwm_gen_1_duty_cycle(d1), .reg_pwm_gen_2_duty_cycle(d2),
        .reg_pwm_gen_3_duty_cycle(d3), .reg_pwm_gen_4_duty_cycle(d4),
        .reg_pwm_frequency_divider(fdiv), .txn_done(txn_done), .txn_err(txn_err));

    always #5 clk = ~clk;

    logic [71:0] dut_regs;
    assign dut_regs = {4'h0, fdiv, d4, d3, d2, d1, reg_out_7_4_pwm_chanel,
                       reg_out_3_0_pwm_chanel, reg_en_pwm_out, reg_en_out};

    typedef struct {
        logic [15:0] w;
        int          nbits;
        int          half;
        bit          done;
    } vec_t;

    typedef struct {
        bit          done;
        int          n;
        logic [71:0] regs;
    } exp_t;

    exp_t       sbq[$];
    logic [7:0] model [0:8];
    int checks = 0, errors = 0, cyc = 0, pulse_cnt = 0, done_cnt = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [71:0] pack_model();
        logic [71:0] r;
        for (int i = 0; i < 9; i++) r[8*i +: 8] = model[i];
        return r;
    endfunction

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every pulse must match the oldest outstanding frame.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (txn_done && txn_err) begin
                checks++; errors++;
                $display("FAIL done_err_both got 1 expected 0 at cycle %0d", cyc);
            end
            if (txn_done || txn_err) begin
                pulse_cnt++;
                if (txn_done) done_cnt++;
                if (sbq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pulse got done=%0b err=%0b expected none at cycle %0d",
                             txn_done, txn_err, cyc);
                end else begin
                    it = sbq.pop_front();
                    chk("pulse_kind", {70'h0, txn_done, txn_err}, {70'h0, it.done, !it.done});
                    chk("pulse_latency", 72'(cyc - it.n), 72'(S + 1));
                    chk("regs_at_pulse", dut_regs, it.regs);
                end
            end
        end
    end

    task automatic send_frame(input logic [15:0] w, input int nbits, input int half, input bit done);
        exp_t it;
        @(negedge clk);
        ncs = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < 16) ? w[15-i] : 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b1;
            repeat (half) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        if (done) begin
            if (w[14:8] == 7'h08) model[8] = {4'h0, w[3:0]};
            else                  model[w[14:8]] = w[7:0];
        end
        it.done = done;
        it.n    = cyc + 1;
        it.regs = pack_model();
        sbq.push_back(it);
        ncs = 1'b1;
        repeat (S + 2) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sbq.size() != 0; i++) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL pulse_timeout got %0d pending expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    vec_t vecs[$];

    initial begin
        int pc0, dc0;
        logic [15:0] w;
        vecs.push_back('{16'h80FF, 16, S + 1, 1'b1});
        vecs.push_back('{16'h8455, 16, S + 1, 1'b1});
        vecs.push_back('{16'h88AB, 16, S + 1, 1'b1});
        vecs.push_back('{16'h0012, 16, S + 1, 1'b0});
        vecs.push_back('{16'h8922, 16, S + 1, 1'b0});
        vecs.push_back('{16'h853C, 16, S + 1, 1'b1});
        vecs.push_back('{16'h85A5, 15, S + 1, 1'b0});
        vecs.push_back('{16'h85A5, 17, S + 1, 1'b0});
        vecs.push_back('{16'h0000,  0, S + 2, 1'b0});
        vecs.push_back('{16'h82C3, 16, 7,     1'b1});
        vecs.push_back('{16'h87FF, 16, S + 1, 1'b1});

        for (int i = 0; i < 9; i++) model[i] = 8'h00;
        rst_n = 1'b0; ncs = 1'b1; sclk = 1'b0; copi = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_regs", dut_regs, 72'h0);
        chk("reset_pulses", {70'h0, txn_done, txn_err}, 72'h0);
        rst_n = 1'b1;
        repeat (S + 3) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i].w, vecs[i].nbits, vecs[i].half, vecs[i].done);
            drain();
        end
        chk("en_out_ff", 72'(reg_en_out), 72'hFF);
        chk("duty1_55", 72'(d1), 72'h55);
        chk("fdiv_b", 72'(fdiv), 72'hB);
        chk("duty2_kept", 72'(d2), 72'h3C);
        chk("ch30_c3", 72'(reg_out_3_0_pwm_chanel), 72'hC3);

        // Back-to-back writes to every address with minimum ncs high time.
        dc0 = done_cnt;
        for (int a = 0; a < 9; a++) begin
            w = {1'b1, 7'(a), 8'(8'h11 * (a + 1))};
            send_frame(w, 16, S + 1, 1'b1);
        end
        drain();
        chk("b2b_done_count", 72'(done_cnt - dc0), 72'd9);
        for (int a = 0; a < 8; a++)
            chk("b2b_reg", 72'(dut_regs[8*a +: 8]), 72'(8'h11 * (a + 1)));
        chk("b2b_fdiv", 72'(fdiv), 72'h9);

        // Reset in the middle of a frame; the remainder of that frame must be ignored.
        pc0 = pulse_cnt;
        w = 16'h8177;
        @(negedge clk);
        ncs = 1'b0;
        repeat (S + 1) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            copi = w[15-i];
            repeat (S + 1) @(negedge clk);
            sclk = 1'b1;
            repeat (S + 1) @(negedge clk);
            sclk = 1'b0;
        end
        #3 rst_n = 1'b0;
        #1;
        chk("midreset_regs", dut_regs, 72'h0);
        chk("midreset_pulses", {70'h0, txn_done, txn_err}, 72'h0);
        for (int i = 0; i < 9; i++) model[i] = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 6; i < 16; i++) begin
            copi = w[15-i];
            repeat (S + 1) @(negedge clk);
            sclk = 1'b1;
            repeat (S + 1) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (S + 1) @(negedge clk);
        ncs = 1'b1;
        repeat (20) @(negedge clk);
        chk("partial_ignored", 72'(pulse_cnt - pc0), 72'd0);
        chk("partial_regs", dut_regs, 72'h0);
        send_frame(16'h8177, 16, S + 1, 1'b1);
        drain();
        chk("post_reset_write", 72'(reg_en_pwm_out), 72'h77);
        chk("post_reset_other", 72'(reg_en_out), 72'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
